// File: rtl/mask_stream_gen_pkg.sv
// Shared definitions for the synthetic binary-mask video source.
//   - pattern mode encoding
//   - FSM state encoding
//   - LFSR tap mask, reset value and zero-seed fallback
//   - registered output bundle type
package mask_stream_gen_pkg;

  typedef enum logic [1:0] {
    MODE_ZERO  = 2'd0,
    MODE_RECT  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_LFSR  = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Fibonacci x^16+x^14+x^13+x^11+1, shifting right: feedback from bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS          = 16'h002D;
  localparam logic [15:0] LFSR_SEED_FALLBACK = 16'h0001;
  localparam logic [15:0] LFSR_RESET         = 16'h0001;

  // Frame parameters frozen at frame start.
  typedef struct packed {
    mode_e      mode;
    logic [9:0] x0;
    logic [9:0] x1;
    logic [9:0] y0;
    logic [9:0] y1;
  } shadow_t;

  typedef struct packed {
    logic mask;
    logic de;
    logic hsync;
    logic vsync;
    logic frame_start;
  } pix_out_t;

  // An all-zero state would lock the LFSR, so it is never loaded.
  function automatic logic [15:0] safe_seed(input logic [15:0] seed);
    return (seed == 16'h0000) ? LFSR_SEED_FALLBACK : seed;
  endfunction

endpackage

// File: rtl/mask_stream_gen_lfsr16.sv
// 16-bit Fibonacci LFSR used for the noise pattern.
// Ports:
//   clk, rst (sync, active-low), ce (clock enable)
//   load_i / seed_i : load seed (zero replaced by fallback), has priority over step
//   step_i          : advance one position
//   bit_o           : current bit 0 (value before any pending step)
module lfsr16
  import mask_stream_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        load_i,
  input  logic [15:0] seed_i,
  input  logic        step_i,
  output logic        bit_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // NOTE: every signal driven in always_comb gets a default first so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = safe_seed(seed_i);
    end else if (step_i) begin
      lfsr_d = {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr_q <= LFSR_RESET;
    end else if (ce) begin
      lfsr_q <= lfsr_d;
    end
  end

  assign bit_o = lfsr_q[0];

endmodule

// File: rtl/mask_stream_gen.sv
// Synthetic binary-mask video source: raster timing with programmable
// active/blanking sizes, active area filled with a selectable pattern.
// Ports:
//   clk, rst (sync, active-low), ce (clock enable, holds everything when 0)
//   enable          : run request, sampled in IDLE and at the last pixel of a frame
//   mode            : 0 zeros, 1 rectangle, 2 checkerboard, 3 LFSR noise
//   rect_x0/x1/y0/y1: inclusive rectangle bounds
//   seed            : LFSR seed (0 behaves as 1)
//   mask, out_de, out_hsync, out_vsync, frame_start : registered outputs
module mask_stream_gen
  import mask_stream_gen_pkg::*;
#(
  parameter int H_ACTIVE  = 64,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 8,
  parameter int H_BP      = 16,
  parameter int V_ACTIVE  = 48,
  parameter int V_FP      = 2,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 4,
  parameter int CELL_LOG2 = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [9:0]  rect_x0,
  input  logic [9:0]  rect_x1,
  input  logic [9:0]  rect_y0,
  input  logic [9:0]  rect_y1,
  input  logic [15:0] seed,
  output logic        mask,
  output logic        out_de,
  output logic        out_hsync,
  output logic        out_vsync,
  output logic        frame_start
);

  // 11-bit so a total of exactly 1024 is representable.
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] H_LAST   = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] V_LAST   = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  state_e     state_q, state_d;
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  shadow_t    shadow_q, shadow_d;
  pix_out_t   out_q, out_d;

  logic       lfsr_load;
  logic       lfsr_step;
  logic       lfsr_bit;

  logic [10:0] h_x, v_x;
  logic        de_c, hs_c, vs_c, last_h, last_v;
  logic        in_rect, pattern_c;

  assign h_x    = {1'b0, h_q};
  assign v_x    = {1'b0, v_q};
  assign de_c   = (h_x < H_ACT) && (v_x < V_ACT);
  assign hs_c   = (h_x >= HS_START) && (h_x < HS_END);
  assign vs_c   = (v_x >= VS_START) && (v_x < VS_END);
  assign last_h = (h_x == H_LAST);
  assign last_v = (v_x == V_LAST);

  // An inverted range (x0>x1 or y0>y1) can never satisfy both bounds,
  // so empty rectangles fall out with no extra logic.
  assign in_rect = (h_q >= shadow_q.x0) && (h_q <= shadow_q.x1) &&
                   (v_q >= shadow_q.y0) && (v_q <= shadow_q.y1);

  always_comb begin
    pattern_c = 1'b0;
    unique case (shadow_q.mode)
      MODE_ZERO:  pattern_c = 1'b0;
      MODE_RECT:  pattern_c = in_rect;
      MODE_CHECK: pattern_c = h_q[CELL_LOG2] ^ v_q[CELL_LOG2];
      MODE_LFSR:  pattern_c = lfsr_bit;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    h_d       = h_q;
    v_d       = v_q;
    shadow_d  = shadow_q;
    out_d     = '0;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        h_d = '0;
        v_d = '0;
        if (enable) begin
          state_d         = ST_RUN;
          shadow_d.mode   = mode_e'(mode);
          shadow_d.x0     = rect_x0;
          shadow_d.x1     = rect_x1;
          shadow_d.y0     = rect_y0;
          shadow_d.y1     = rect_y1;
          // Loading the LFSR now is the seed latch: it is only reloaded here
          // and at the frame wrap, so live seed changes wait for frame start.
          lfsr_load       = 1'b1;
        end
      end

      ST_RUN: begin
        out_d.de          = de_c;
        out_d.hsync       = hs_c;
        out_d.vsync       = vs_c;
        out_d.mask        = de_c & pattern_c;
        out_d.frame_start = (h_q == '0) && (v_q == '0);
        lfsr_step         = de_c;

        if (!last_h) begin
          h_d = h_q + 10'd1;
        end else begin
          h_d = '0;
          if (!last_v) begin
            v_d = v_q + 10'd1;
          end else begin
            v_d = '0;
            if (enable) begin
              shadow_d.mode = mode_e'(mode);
              shadow_d.x0   = rect_x0;
              shadow_d.x1   = rect_x1;
              shadow_d.y0   = rect_y0;
              shadow_d.y1   = rect_y1;
              lfsr_load     = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      h_q      <= '0;
      v_q      <= '0;
      shadow_q <= '0;
      out_q    <= '0;
    end else if (ce) begin
      state_q  <= state_d;
      h_q      <= h_d;
      v_q      <= v_d;
      shadow_q <= shadow_d;
      out_q    <= out_d;
    end
  end

  lfsr16 u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .ce     (ce),
    .load_i (lfsr_load),
    .seed_i (seed),
    .step_i (lfsr_step),
    .bit_o  (lfsr_bit)
  );

  assign mask        = out_q.mask;
  assign out_de      = out_q.de;
  assign out_hsync   = out_q.hsync;
  assign out_vsync   = out_q.vsync;
  assign frame_start = out_q.frame_start;

endmodule

// File: tb/tb_mask_stream_gen.sv
// Self-checking bench for mask_stream_gen with a small 14x7 raster.
// A position-based reference model predicts every registered output; the
// prediction is queued before each edge and compared after it. A table of
// pattern vectors checks per-frame counts, and hand-written sequences cover
// enable drop, clock-enable stall, mid-frame reset and live rect changes.
module tb_mask_stream_gen;

  localparam int HT    = 14;
  localparam int VT    = 7;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst, ce, enable;
  logic [1:0]  mode;
  logic [9:0]  rect_x0, rect_x1, rect_y0, rect_y1;
  logic [15:0] seed;
  logic        mask, out_de, out_hsync, out_vsync, frame_start;

  always #5 clk = ~clk;

  mask_stream_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CELL_LOG2(1)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .enable(enable), .mode(mode),
    .rect_x0(rect_x0), .rect_x1(rect_x1), .rect_y0(rect_y0), .rect_y1(rect_y1),
    .seed(seed), .mask(mask), .out_de(out_de), .out_hsync(out_hsync),
    .out_vsync(out_vsync), .frame_start(frame_start)
  );

  typedef struct packed {
    logic mask;
    logic de;
    logic hs;
    logic vs;
    logic fs;
  } obs_t;

  obs_t exp_q[$];
  obs_t last_got;
  int   checks = 0;
  int   errors = 0;

  // Per-run observation counters (only ce-qualified cycles are counted).
  int   c_mask, c_de, c_hs, c_vs, c_fs;
  logic mask_seq[$];

  // Reference model state.
  int          m_pos = -1;
  int          m_x0, m_x1, m_y0, m_y1;
  logic [1:0]  m_mode;
  logic [15:0] m_lfsr = 16'h0001;
  obs_t        m_last = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

  task automatic model_latch();
    m_mode = mode;
    m_x0   = int'(rect_x0);
    m_x1   = int'(rect_x1);
    m_y0   = int'(rect_y0);
    m_y1   = int'(rect_y1);
    m_lfsr = (seed == 16'h0) ? 16'h0001 : seed;
  endtask

  // Predicts outputs after the coming edge from the current inputs.
  task automatic model_edge(output obs_t e);
    int h, v;
    e = '0;
    if (!rst) begin
      m_pos  = -1;
      m_lfsr = 16'h0001;
    end else if (!ce) begin
      e = m_last;
    end else if (m_pos < 0) begin
      if (enable) begin
        model_latch();
        m_pos = 0;
      end
    end else begin
      h    = m_pos % HT;
      v    = m_pos / HT;
      e.de = (h < 8) && (v < 4);
      e.hs = (h >= 10) && (h < 12);
      e.vs = (v == 5);
      e.fs = (m_pos == 0);
      if (e.de) begin
        case (m_mode)
          2'd1:    e.mask = (h >= m_x0) && (h <= m_x1) && (v >= m_y0) && (v <= m_y1);
          2'd2:    e.mask = (((h / 2) % 2) != ((v / 2) % 2));
          2'd3:    e.mask = m_lfsr[0];
          default: e.mask = 1'b0;
        endcase
        m_lfsr = lfsr_next(m_lfsr);
      end
      if (m_pos == FRAME - 1) begin
        if (enable) begin
          model_latch();
          m_pos = 0;
        end else begin
          m_pos = -1;
        end
      end else begin
        m_pos++;
      end
    end
    m_last = e;
  endtask

  // One clock: predict, push, let the edge happen, pop and compare.
  task automatic cycle();
    obs_t e, got;
    logic ce_s;
    ce_s = ce;
    model_edge(e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got      = {mask, out_de, out_hsync, out_vsync, frame_start};
    last_got = got;
    e        = exp_q.pop_front();
    check("pixel{mask,de,hs,vs,fs}", 32'(got), 32'(e));
    if (ce_s) begin
      c_mask += int'(got.mask);
      c_de   += int'(got.de);
      c_hs   += int'(got.hs);
      c_vs   += int'(got.vs);
      c_fs   += int'(got.fs);
      if (got.de) mask_seq.push_back(got.mask);
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clear_counts();
    c_mask = 0; c_de = 0; c_hs = 0; c_vs = 0; c_fs = 0;
    mask_seq.delete();
  endtask

  function automatic logic [31:0] get_seq();
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < 32 && i < mask_seq.size(); i++) s[i] = mask_seq[i];
    return s;
  endfunction

  task automatic check_timing(input string tag);
    check({tag, "_de_count"},    32'(c_de), 32'd32);
    check({tag, "_hsync_count"}, 32'(c_hs), 32'd14);
    check({tag, "_vsync_count"}, 32'(c_vs), 32'd14);
    check({tag, "_fs_count"},    32'(c_fs), 32'd1);
  endtask

  // Start from IDLE, run exactly one frame with enable dropped right after start.
  task automatic one_frame();
    enable = 1'b1;
    cycle();
    enable = 1'b0;
    clear_counts();
    run(FRAME);
  endtask

  task automatic set_rect(input int x0, input int x1, input int y0, input int y1);
    rect_x0 = 10'(x0); rect_x1 = 10'(x1); rect_y0 = 10'(y0); rect_y1 = 10'(y1);
  endtask

  typedef struct {
    logic [1:0]  mode;
    int          x0, x1, y0, y1;
    logic [15:0] seed;
    int          exp_mask;   // -1: count not checked (noise)
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [31:0] seq_a, seq_b;

    vecs[0] = '{2'd0, 0, 7, 0, 3, 16'h0000, 0};
    vecs[1] = '{2'd1, 2, 4, 1, 2, 16'h0000, 6};
    vecs[2] = '{2'd1, 5, 3, 1, 2, 16'h0000, 0};
    vecs[3] = '{2'd1, 2, 4, 2, 1, 16'h0000, 0};
    vecs[4] = '{2'd1, 0, 7, 0, 3, 16'h0000, 32};
    vecs[5] = '{2'd1, 7, 9, 3, 6, 16'h0000, 1};
    vecs[6] = '{2'd2, 0, 0, 0, 0, 16'h0000, 16};
    vecs[7] = '{2'd3, 0, 0, 0, 0, 16'hACE1, -1};

    rst = 1'b0; ce = 1'b1; enable = 1'b0; mode = 2'd0; seed = 16'h0;
    set_rect(0, 0, 0, 0);
    run(3);
    check("reset_outputs", 32'(last_got), 32'd0);
    rst = 1'b1;
    run(2);

    // Pattern table, one frame each.
    foreach (vecs[i]) begin
      mode = vecs[i].mode;
      set_rect(vecs[i].x0, vecs[i].x1, vecs[i].y0, vecs[i].y1);
      seed = vecs[i].seed;
      one_frame();
      check_timing($sformatf("vec%0d", i));
      if (vecs[i].exp_mask >= 0)
        check($sformatf("vec%0d_mask_count", i), 32'(c_mask), 32'(vecs[i].exp_mask));
      cycle();
      check($sformatf("vec%0d_idle_after", i), 32'(last_got), 32'd0);
    end

    // Checkerboard line patterns.
    mode = 2'd2;
    one_frame();
    seq_a = get_seq();
    check("check_line0", 32'(seq_a[7:0]), 32'h0CC);
    check("check_line2", 32'(seq_a[23:16]), 32'h033);
    cycle();

    // LFSR repeats across two back-to-back frames.
    mode = 2'd3; seed = 16'hACE1; enable = 1'b1;
    cycle();
    clear_counts();
    run(FRAME);
    seq_a = get_seq();
    enable = 1'b0;
    clear_counts();
    run(FRAME);
    seq_b = get_seq();
    check("lfsr_frame_repeat", seq_b, seq_a);
    check("lfsr_first_bits", 32'(seq_a[2:0]), 32'h1);
    cycle();

    // Seed 0 behaves as seed 1.
    seed = 16'h0000;
    one_frame();
    seq_a = get_seq();
    cycle();
    seed = 16'h0001;
    one_frame();
    seq_b = get_seq();
    check("seed0_eq_seed1", seq_a, seq_b);
    cycle();

    // Enable dropped at v=1: frame completes, then idle.
    mode = 2'd1; set_rect(2, 4, 1, 2); enable = 1'b1;
    cycle();
    clear_counts();
    run(HT);
    enable = 1'b0;
    run(FRAME - HT);
    check_timing("drop_en");
    check("drop_en_mask_count", 32'(c_mask), 32'd6);
    clear_counts();
    run(5);
    check("drop_en_idle_de", 32'(c_de), 32'd0);
    check("drop_en_idle_out", 32'(last_got), 32'd0);

    // ce stall mid-line: frozen outputs, remainder of frame unchanged.
    enable = 1'b1;
    cycle();
    enable = 1'b0;
    clear_counts();
    run(20);
    ce = 1'b0;
    run(5);
    ce = 1'b1;
    run(FRAME - 20);
    check_timing("stall");
    check("stall_mask_count", 32'(c_mask), 32'd6);
    cycle();

    // Reset at v=2 aborts at once.
    enable = 1'b1;
    cycle();
    run(2 * HT);
    rst = 1'b0;
    cycle();
    check("midframe_reset_out", 32'(last_got), 32'd0);
    rst = 1'b1;
    enable = 1'b0;
    run(3);
    check("post_reset_idle", 32'(last_got), 32'd0);

    // Rect changed mid-frame takes effect at the next frame only.
    set_rect(2, 4, 1, 2); enable = 1'b1;
    cycle();
    clear_counts();
    run(10);
    set_rect(0, 7, 0, 3);
    run(FRAME - 10);
    check("rect_live_cur_frame", 32'(c_mask), 32'd6);
    enable = 1'b0;
    clear_counts();
    run(FRAME);
    check("rect_live_next_frame", 32'(c_mask), 32'd32);
    run(2);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mask_stream_gen.md
# mask_stream_gen

Synthetic source for the binary-mask video stream (mask, de, hsync, vsync) consumed by the skin-colour morphology chain. It produces raster timing with programmable active/blanking sizes and fills the active area with a selectable mask pattern. It replaces the camera and colour-segmentation front end in simulation and board bring-up, so the erosion and dilation stages can be driven with known frames.

## Interface
Parameters:
- H_ACTIVE, 64, active pixels per line (≥1)
- H_FP, 16, horizontal front porch, in pixels
- H_SYNC, 8, hsync width, in pixels
- H_BP, 16, horizontal back porch, in pixels
- V_ACTIVE, 48, active lines per frame
- V_FP, 2, vertical front porch, in lines
- V_SYNC, 2, vsync width, in lines
- V_BP, 4, vertical back porch, in lines
- CELL_LOG2, 2, log2 of the checkerboard cell edge (cell edge is 4 px by default)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low (0 = reset)
- ce  in  1  clock enable; when 0 all state and outputs hold
- enable  in  1  run request
- mode  in  2  pattern: 0 all zeros, 1 rectangle, 2 checkerboard, 3 LFSR noise
- rect_x0, rect_x1  in  10  inclusive rectangle column bounds
- rect_y0, rect_y1  in  10  inclusive rectangle row bounds
- seed  in  16  LFSR seed
- mask  out  1  mask pixel
- out_de  out  1  data enable
- out_hsync  out  1  horizontal sync, active-high
- out_vsync  out  1  vertical sync, active-high
- frame_start  out  1  one-cycle pulse, coincident with pixel (0,0) on the outputs

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is the vertical equivalent. Both must be ≤1024. Counters h and v are 10-bit.
- FSM states: IDLE and RUN.
- IDLE: counters are 0 and all outputs are 0.
  - On a ce edge with enable=1, latch mode, rect and seed into shadow registers, then go to RUN.
- RUN: on each ce edge, the outputs are registered from the decode of (h,v), then h advances.
  - When h wraps, v advances.
  - At (H_TOTAL-1, V_TOTAL-1), if enable=1: wrap to (0,0) and re-latch the shadow registers.
  - Otherwise: go to IDLE.
- Dropping enable mid-frame never truncates a frame.
- Decode rules:
  - de = h<H_ACTIVE && v<V_ACTIVE
  - hsync = H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC, on every line including vertical blanking
  - vsync = V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC, for the whole line
- Pattern rules. mask is forced to 0 whenever de=0.
  - rectangle: x0≤h≤x1 && y0≤v≤y1. If x0>x1 or y0>y1, the mask is all zeros.
  - checkerboard: h[CELL_LOG2] XOR v[CELL_LOG2]
  - LFSR: Fibonacci, x^16+x^14+x^13+x^11+1.
    - Loaded with the shadow seed at frame start. A seed of 0 is replaced by 16'h0001.
    - Steps once per de pixel. mask = LFSR bit 0 before the step.
- Live changes to mode, rect or seed take effect only at the next frame start.

## Timing
- All outputs are registered.
- Reset: state IDLE, counters 0, mask, out_de, out_hsync, out_vsync and frame_start all 0. LFSR = 16'h0001.
- Reset applied mid-frame aborts immediately; outputs are 0 on the next edge.
- Latency: enable sampled high at ce edge N (IDLE→RUN). Pixel (0,0) and frame_start appear after ce edge N+1.
- Back-to-back frames are contiguous: pixel (0,0) of frame k+1 follows (H_TOTAL-1, V_TOTAL-1) of frame k with no gap.
- After the last pixel of a frame with enable=0, outputs return to 0 on the following ce edge.
- ce=0 stalls all of the above. Counts are in ce-qualified cycles.

## Structure
- Shared header mask_gen_defs.vh holds:
  - mode constants MODE_ZERO, MODE_RECT, MODE_CHECK, MODE_LFSR
  - the LFSR tap mask and the nonzero-seed fallback value
- Sub-module lfsr16 holds the 16-bit register, with load (seed) and step inputs.
- Target size: approximately 200 lines of RTL.

## Test plan
Common bench parameters: H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2 (H_TOTAL=14); V_ACTIVE=4, V_FP=V_SYNC=V_BP=1 (V_TOTAL=7); frame = 98 cycles.

- Timing, mode 0, enable held:
  - out_de is high 8 cycles out of every 14, on lines 0–3 only.
  - out_hsync is high at h=10..11 on all 7 lines.
  - out_vsync is high for all 14 cycles of line 5.
  - frame_start fires every 98 cycles. mask is always 0.
- Rectangle x0=2, x1=4, y0=1, y1=2:
  - Exactly 6 mask=1 pixels per frame, at (2..4, 1..2).
  - x0=5, x1=3 gives 0 mask pixels.
- Checkerboard with CELL_LOG2=1:
  - Line 0 mask = 0,0,1,1,0,0,1,1.
  - Line 2 is the inverse of line 0.
- LFSR:
  - seed=16'hACE1 gives the same 32-pixel mask sequence in two consecutive frames.
  - seed=0 matches seed=1.
- Control:
  - Drop enable at v=1: the frame completes, then the block goes idle with outputs 0.
  - Hold ce=0 for 5 cycles mid-line: outputs are frozen for those cycles and the remaining frame is unchanged.
  - Assert rst at v=2: outputs are 0 the next cycle.
  - Change rect mid-frame: the current frame is unaffected.
